// File: rtl/piso_arb_ctrl_if.sv
// piso_arb_ctrl_if: requester handshakes and serial output of the PISO arbiter
// master: requester side (drives valid/data, observes ready and serial outputs)
// slave : controller side (accepts valid/data, drives ready and serial outputs)
interface piso_arb_ctrl_if #(parameter int WIDTH = 4);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             sout;
  logic             sout_valid;
  logic             grant_id;
  logic             busy;
  logic             done;
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, sout, sout_valid, grant_id, busy, done
  );
  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, sout, sout_valid, grant_id, busy, done
  );
endinterface

// File: rtl/piso_arb_ctrl.sv
// piso_arb_ctrl: round-robin arbiter of two requesters feeding an MSB-first PISO with inter-frame gap
// Ports: clk (rising edge), rst (async active-low), bus (piso_arb_ctrl_if.slave: req0/req1 valid/data/ready,
//        sout, sout_valid, grant_id, busy, done)
// Option: define PISO_PARITY_EN to append an even-parity bit after the data bits of every frame
module piso_arb_ctrl #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input logic            clk,
  input logic            rst,
  piso_arb_ctrl_if.slave bus
);
`ifdef PISO_PARITY_EN
  localparam int SW = WIDTH + 1;
`else
  localparam int SW = WIDTH;
`endif
  localparam int CW = $clog2(SW);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t           state_q, state_d;
  logic [SW-1:0]    shift_q, shift_d, load;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gap_q, gap_d;
  logic             last_q, last_d, grant_q, grant_d;
  logic             idle, win1, take;
  logic [WIDTH-1:0] win_data;
  assign idle = state_q == IDLE;
  // req1 wins when alone, or when both are valid and req0 owned the previous frame
  assign win1 = bus.req1_valid && (!bus.req0_valid || !last_q);
  // ready is gated by rst so nothing is accepted while reset is held
  assign bus.req0_ready = rst && idle && bus.req0_valid && !win1;
  assign bus.req1_ready = rst && idle && win1;
  assign take     = bus.req0_ready || bus.req1_ready;
  assign win_data = win1 ? bus.req1_data : bus.req0_data;
`ifdef PISO_PARITY_EN
  assign load = {win_data, ^win_data};
`else
  assign load = win_data;
`endif
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    last_d  = last_q;
    grant_d = grant_q;
    if (idle && take) begin
      state_d = SHIFT;
      shift_d = load;
      cnt_d   = CW'(SW - 1);
      last_d  = win1;
      grant_d = win1;
    end else if (state_q == SHIFT) begin
      shift_d = shift_q << 1;
      cnt_d   = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
      state_d = (cnt_q != '0) ? SHIFT : (GAP_CYCLES > 0) ? GAP : IDLE;
      gap_d   = (cnt_q == '0) ? 4'(GAP_CYCLES - 1) : gap_q;
    end else if (state_q == GAP) begin
      gap_d   = (gap_q == '0) ? '0 : gap_q - 1'b1;
      state_d = (gap_q == '0) ? IDLE : GAP;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      last_q  <= 1'b1;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end
  assign bus.sout       = (state_q == SHIFT) && shift_q[SW-1];
  assign bus.sout_valid = state_q == SHIFT;
  assign bus.done       = (state_q == SHIFT) && (cnt_q == '0);
  assign bus.busy       = !idle;
  assign bus.grant_id   = grant_q;
endmodule

// File: doc/piso_arb_ctrl.md
Name: piso_arb_ctrl

Overview:
- Controller and arbiter for the 4-bit parallel-in/serial-out shift path.
- Two requesters present parallel words over valid/ready handshakes.
- The block grants one requester at a time with round-robin priority, loads the shift register and shifts the word out MSB first with a frame-valid strobe.
- It then enforces an inter-frame gap before the next grant.

Parameters:
- WIDTH, 4, serial word width in bits (>=2).
- GAP_CYCLES, 1, idle cycles inserted after each frame (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has a word.
- req0_data  input  WIDTH  requester 0 parallel word.
- req0_ready  output  1  requester 0 word accepted this cycle.
- req1_valid  input  1  requester 1 has a word.
- req1_data  input  WIDTH  requester 1 parallel word.
- req1_ready  output  1  requester 1 word accepted this cycle.
- sout  output  1  serial data out.
- sout_valid  output  1  sout carries a frame bit.
- grant_id  output  1  requester owning the current frame.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse on the last bit of a frame.

Behaviour:
- Reset (rst low, async): state=IDLE; shift reg=0; bit counter=0; gap counter=0; last_grant=1, so req0 wins first. Outputs: sout=0, sout_valid=0, grant_id=0, busy=0, done=0. Ready outputs are therefore 0 during reset.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - The winner is chosen combinationally among valid requesters. If both are valid, the one not equal to last_grant wins.
  - readyN=1 only for the winner; the loser's ready stays 0. Ready is never asserted outside IDLE.
  - A transfer occurs when validN&&readyN. At that edge: shift reg<=reqN_data, grant_id<=N, last_grant<=N, bit counter<=WIDTH-1, state->SHIFT.
  - With no valid request, the FSM stays in IDLE.
- SHIFT:
  - sout=shift reg MSB; sout_valid=1. Each edge shifts left, filling with 0, and decrements the counter.
  - Bit k of a frame (k=0..WIDTH-1) appears in the k+1-th cycle after the handshake edge. Latency from handshake to first bit = 1 cycle.
  - done=1 in the cycle where the counter==0, i.e. the last bit. Next state: GAP if GAP_CYCLES>0, else IDLE.
- GAP: sout=0, sout_valid=0, busy=1 for exactly GAP_CYCLES cycles, then IDLE.
- Minimum spacing between frames: at least one IDLE cycle, since ready is only asserted in IDLE. Handshake-to-handshake period = WIDTH+GAP_CYCLES+1 cycles.
- Data is sampled only at the handshake edge. Changes to reqN_data afterwards do not affect the frame in flight.
- A requester dropping valid before it is granted is legal; no state is retained for it.
- Reset mid-frame: the frame is aborted immediately, with no done pulse. After release the FSM restarts from IDLE with req0 priority.
- sout, sout_valid and done are registered or decoded from registered state only, with no combinational path from inputs. ready depends combinationally on valid and state.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined: after the WIDTH data bits, one extra SHIFT cycle drives the even-parity bit of the loaded word (XOR of all bits). sout_valid stays high for WIDTH+1 cycles, and done moves to the parity cycle. Handshake period becomes WIDTH+GAP_CYCLES+2.
- Undefined: no parity cycle, and the parity logic is absent.

Test Plan (WIDTH=4, GAP_CYCLES=1, macro undefined unless stated):
- Reset: hold rst=0 with both valids high -> both ready=0, sout=0, sout_valid=0, busy=0. Release -> req0_ready=1 in the first IDLE cycle.
- Single frame: req0 sends 4'b1010 at edge T -> sout=1,0,1,0 with sout_valid=1 in cycles T+1..T+4; done only in T+4; grant_id=0; cycle T+5 GAP (sout_valid=0, busy=1); T+6 IDLE, busy=0.
- Round-robin: both valid continuously, req0=4'b0011, req1=4'b1101 -> grants alternate 0,1,0,1. The serial streams are 0011 then 1101. Handshakes are 6 cycles apart.
- Data hold: after req1's handshake with 4'b1100, change req1_data to 4'b0001 -> the serial output is still 1,1,0,0.
- Reset mid-frame: assert rst low after the 2nd bit of 4'b1111 -> sout/sout_valid drop to 0 immediately, with no done. After release, req1 valid only -> req1 is granted.
- PISO_PARITY_EN defined: send 4'b1011 -> sout=1,0,1,1,1 across 5 valid cycles (parity bit 1), with done on the 5th.
